// File: rtl/shift_unit_scheduler.sv
// Shares one external left-only barrel shifter between two requesters and
// derives SLL, SRL and SRA from it, with round-robin arbitration.
module shift_unit_scheduler #(
  parameter int XLEN      = 32,
  parameter int SHW       = 5,
  parameter int FIRST_PRI = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_op,
  input  logic [XLEN-1:0] req0_data,
  input  logic [SHW-1:0]  req0_amt,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_op,
  input  logic [XLEN-1:0] req1_data,
  input  logic [SHW-1:0]  req1_amt,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_data,
  output logic [XLEN-1:0] sh_water,
  output logic [XLEN-1:0] sh_shift,
  input  logic [XLEN-1:0] sh_wine,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  // Handshakes: a request transfers on a rising edge where reqN_valid and
  // reqN_ready are both high; the result transfers where resp_valid and
  // resp_ready are both high. Valid may drop before ready without effect.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS_D = 2'd1,
    PASS_M = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t            state;
  state_t            state_nxt;
  logic              rr_last;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   data_q;
  logic [SHW-1:0]    amt_q;
  logic              id_q;
  logic [XLEN-1:0]   res_q;
  logic [XLEN-1:0]   res_nxt;
  logic [XLEN-1:0]   fill;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              is_right;

  function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

  // Arbitration: a lone valid wins; on contention the requester that did
  // not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = rr_last;
        grant1 = ~rr_last;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign is_right   = (op_q == OP_SRL) || (op_q == OP_SRA);

  always_comb begin
    state_nxt = state;
    sh_water  = '0;
    sh_shift  = '0;
    res_nxt   = res_q;
    fill      = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = PASS_D;
      end
      PASS_D: begin
        sh_water = is_right ? rev(data_q) : data_q;
        if (op_q != OP_PASS) sh_shift = {{(XLEN-SHW){1'b0}}, amt_q};
        res_nxt   = is_right ? rev(sh_wine) : sh_wine;
        state_nxt = (op_q == OP_SRA) ? PASS_M : RESP;
      end
      PASS_M: begin
        // All-ones shifted left by amt, reversed and inverted, leaves ones
        // in exactly the top amt bits: the sign-extension region.
        sh_water  = '1;
        sh_shift  = {{(XLEN-SHW){1'b0}}, amt_q};
        fill      = ~rev(sh_wine);
        res_nxt   = data_q[XLEN-1] ? (res_q | fill) : res_q;
        state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= (FIRST_PRI == 0) ? 1'b1 : 1'b0;
      op_q      <= '0;
      data_q    <= '0;
      amt_q     <= '0;
      id_q      <= 1'b0;
      res_q     <= '0;
      resp_data <= '0;
      resp_id   <= 1'b0;
    end else begin
      state <= state_nxt;
      res_q <= res_nxt;
      if (accept) begin
        op_q    <= grant1 ? req1_op : req0_op;
        data_q  <= grant1 ? req1_data : req0_data;
        amt_q   <= grant1 ? req1_amt : req0_amt;
        id_q    <= grant1;
        rr_last <= grant1;
      end
      // Response registers change only when a new result is published.
      if ((state == PASS_D || state == PASS_M) && state_nxt == RESP) begin
        resp_data <= res_nxt;
        resp_id   <= id_q;
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_shift_unit_scheduler.sv
// Directed bench for shift_unit_scheduler with a behavioural left shifter
// attached to the sh_* port pair.
module tb_shift_unit_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic [4:0]  req0_amt = '0, req1_amt = '0;
  logic        resp_valid, resp_id;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data, sh_water, sh_shift, sh_wine;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, PASS = 2'b11;

  always #5 clk = ~clk;

  assign sh_wine = sh_water << sh_shift[4:0];

  shift_unit_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_data(req1_data), .req1_amt(req1_amt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .sh_water(sh_water), .sh_shift(sh_shift),
    .sh_wine(sh_wine), .busy(busy), .state_dbg(state_dbg)
  );

  task automatic set_req(input bit id, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] a);
    if (id == 1'b0) begin
      req0_op = op; req0_data = d; req0_amt = a; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_data = d; req1_amt = a; req1_valid = 1'b1;
    end
  endtask

  // Issues one operation and reports cycles from accept edge to resp_valid.
  task automatic run_op(input bit id, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] a, output int lat,
                        output logic [31:0] rd, output logic rid);
    bit acc = 0;
    lat = 0; rd = 'x; rid = 1'bx;
    @(negedge clk);
    set_req(id, op, d, a);
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if ((id == 1'b0) ? req0_ready : req1_ready) acc = 1;
      else @(negedge clk);
    end
    if (acc) begin
      @(posedge clk);
      @(negedge clk);
      lat = 1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (acc) begin
      for (int i = 0; i < 20; i++) begin
        if (resp_valid) begin
          rd = resp_data; rid = resp_id;
          break;
        end
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req0_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    n_cmp++; if (resp_id !== 1'b0) begin n_fail++; $display("FAIL reset_resp_id: got %b want 0", resp_id); end
    n_cmp++; if (sh_water !== 32'h0 || sh_shift !== 32'h0) begin n_fail++; $display("FAIL reset_sh: got %h/%h want 0/0", sh_water, sh_shift); end
    n_cmp++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got busy %b state %0d want 0/0", busy, state_dbg); end
    req0_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic_ops;
    bit          ids [6] = '{0, 1, 1, 0, 1, 0};
    logic [1:0]  ops [6] = '{SLL, SRL, SRA, SRL, PASS, SLL};
    logic [31:0] dat [6] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                             32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_FFFF};
    logic [4:0]  amt [6] = '{5'd31, 5'd4, 5'd4, 5'd8, 5'd7, 5'd0};
    logic [31:0] exp [6] = '{32'h8000_0000, 32'h0800_0000, 32'hF800_0000,
                             32'h00DE_ADBE, 32'h1234_5678, 32'h0000_FFFF};
    int          elat[6] = '{2, 2, 3, 2, 2, 2};
    int lat; logic [31:0] rd; logic rid;
    for (int k = 0; k < 6; k++) begin
      run_op(ids[k], ops[k], dat[k], amt[k], lat, rd, rid);
      n_cmp++; if (lat != elat[k]) begin n_fail++; $display("FAIL op%0d_latency: got %0d want %0d", k, lat, elat[k]); end
      n_cmp++; if (rd !== exp[k]) begin n_fail++; $display("FAIL op%0d_data: got %h want %h", k, rd, exp[k]); end
      n_cmp++; if (rid !== ids[k]) begin n_fail++; $display("FAIL op%0d_id: got %b want %b", k, rid, ids[k]); end
    end
  endtask

  task automatic test_sra_bounds;
    logic [31:0] dat [5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h7FFF_FFFF,
                             32'hDEAD_BEEF, 32'h7FFF_FFFF};
    logic [4:0]  amt [5] = '{5'd0, 5'd31, 5'd31, 5'd4, 5'd4};
    logic [31:0] exp [5] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0000,
                             32'hFDEA_DBEE, 32'h07FF_FFFF};
    int lat; logic [31:0] rd; logic rid;
    for (int k = 0; k < 5; k++) begin
      run_op(1'b0, SRA, dat[k], amt[k], lat, rd, rid);
      n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL sra%0d_latency: got %0d want 3", k, lat); end
      n_cmp++; if (rd !== exp[k]) begin n_fail++; $display("FAIL sra%0d_data: got %h want %h", k, rd, exp[k]); end
    end
  endtask

  task automatic test_round_robin;
    int grants[$];
    int ids[$];
    int want[4] = '{0, 1, 0, 1};
    logic [31:0] e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    set_req(1'b0, SLL, 32'h0000_0001, 5'd1);
    set_req(1'b1, SRL, 32'h8000_0000, 5'd1);
    for (int i = 0; i < 60 && ids.size() < 4; i++) begin
      #1;
      if (req0_ready && req1_ready) begin
        n_cmp++; n_fail++; $display("FAIL rr_double_grant: got both ready want one");
      end
      if (req0_ready) begin grants.push_back(0); exp_q.push_back(32'h0000_0002); end
      if (req1_ready) begin grants.push_back(1); exp_q.push_back(32'h4000_0000); end
      if (resp_valid) begin
        ids.push_back(int'(resp_id));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++; if (resp_data !== e) begin n_fail++; $display("FAIL rr_data: got %h want %h", resp_data, e); end
      end
      if (ids.size() < 4) @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_q.delete();
    n_cmp++; if (ids.size() != 4) begin n_fail++; $display("FAIL rr_count: got %0d responses want 4", ids.size()); end
    for (int k = 0; k < 4 && k < grants.size() && k < ids.size(); k++) begin
      n_cmp++; if (grants[k] != want[k]) begin n_fail++; $display("FAIL rr_grant%0d: got %0d want %0d", k, grants[k], want[k]); end
      n_cmp++; if (ids[k] != want[k]) begin n_fail++; $display("FAIL rr_resp_id%0d: got %0d want %0d", k, ids[k], want[k]); end
    end
  endtask

  task automatic test_backpressure;
    bit seen = 0;
    @(negedge clk);
    resp_ready = 1'b0;
    set_req(1'b0, SLL, 32'h0000_0003, 5'd2);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (resp_valid) seen = 1; else @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL bp_resp_timeout: got no resp_valid want 1"); end
    set_req(1'b1, SLL, 32'h0000_0005, 5'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %b want 1", c, resp_valid); end
      n_cmp++; if (resp_data !== 32'h0000_000C) begin n_fail++; $display("FAIL bp_data%0d: got %h want 0000000c", c, resp_data); end
      n_cmp++; if (resp_id !== 1'b0) begin n_fail++; $display("FAIL bp_id%0d: got %b want 0", c, resp_id); end
      n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b%b want 00", c, req0_ready, req1_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy%0d: got %b want 1", c, busy); end
    end
    @(negedge clk);
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_after%0d: got valid %b busy %b want 0/0", c, resp_valid, busy); end
    end
    n_cmp++; if (resp_data !== 32'h0000_000C) begin n_fail++; $display("FAIL bp_hold_data: got %h want 0000000c", resp_data); end
  endtask

  task automatic test_reset_mid_op;
    bit drop0 = 1, drop1 = 0;
    int n_resp = 0;
    logic [31:0] rdat[2];
    logic        rid[2];
    @(negedge clk);
    set_req(1'b0, SRA, 32'h8000_0000, 5'd4);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_cmp++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL mid_pass_d_state: got %0d want 1", state_dbg); end
    n_cmp++; if (sh_water !== 32'h0000_0001 || sh_shift !== 32'd4) begin n_fail++; $display("FAIL mid_pass_d_sh: got %h/%h want 00000001/00000004", sh_water, sh_shift); end
    @(negedge clk); #1;
    n_cmp++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL mid_pass_m_state: got %0d want 2", state_dbg); end
    n_cmp++; if (sh_water !== 32'hFFFF_FFFF || sh_shift !== 32'd4) begin n_fail++; $display("FAIL mid_pass_m_sh: got %h/%h want ffffffff/00000004", sh_water, sh_shift); end
    rst = 1'b1;
    set_req(1'b0, SLL, 32'h0000_0001, 5'd3);
    #1;
    n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", req0_ready); end
    @(negedge clk); #1;
    n_cmp++; if (state_dbg !== 2'd0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle: got state %0d valid %b want 0/0", state_dbg, resp_valid); end
    rst = 1'b0;
    set_req(1'b1, SLL, 32'h0000_0001, 5'd0);
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_first_grant: got %b%b want 10", req0_ready, req1_ready); end
    for (int i = 0; i < 30 && n_resp < 2; i++) begin
      @(negedge clk);
      if (drop0) req0_valid = 1'b0;
      if (drop1) req1_valid = 1'b0;
      #1;
      if (req1_valid && req1_ready) drop1 = 1;
      if (resp_valid) begin rdat[n_resp] = resp_data; rid[n_resp] = resp_id; n_resp++; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++; if (n_resp != 2) begin n_fail++; $display("FAIL mid_resp_count: got %0d want 2", n_resp); end
    if (n_resp == 2) begin
      n_cmp++; if (rdat[0] !== 32'h0000_0008 || rid[0] !== 1'b0) begin n_fail++; $display("FAIL mid_resp0: got %h id %b want 00000008 id 0", rdat[0], rid[0]); end
      n_cmp++; if (rdat[1] !== 32'h0000_0001 || rid[1] !== 1'b1) begin n_fail++; $display("FAIL mid_resp1: got %h id %b want 00000001 id 1", rdat[1], rid[1]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_ops();
    test_sra_bounds();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
